vga_wbm_rdr: RTL and testbench
==============================

Name: vga_wbm_rdr

Overview:
- Wishbone classic-cycle master (initiator) that reads a block of consecutive words from a Wishbone slave, such as the CLUT shared-memory port.
- It issues one single read cycle per word and buffers the returned data in a 2-entry FIFO.
- The FIFO presents the words on a valid/ready stream.
- It sits between the VGA pixel/CLUT fetch logic and a slave port of the cycle-shared memory.

Parameters:
DWIDTH  32  data bus width; must be a multiple of 8
AWIDTH  8   word address width
CWIDTH  8   transfer-count width

Ports:
wb_clk_i      in   1            clock; all logic on rising edge
rst_nreset_i  in   1            asynchronous active-low reset
start_i       in   1            start request; sampled only when idle
base_adr_i    in   AWIDTH       first word address, captured on start
count_i       in   CWIDTH       number of words, captured on start; 0 means no transfer
busy_o        out  1            transfer in progress
done_o        out  1            1-cycle pulse at transfer end (normal or error)
err_o         out  1            sticky error flag; cleared by the next accepted start
wbm_adr_o     out  AWIDTH       Wishbone address
wbm_dat_o     out  DWIDTH       Wishbone write data; constant 0
wbm_sel_o     out  DWIDTH/8     byte selects; constant all-ones
wbm_we_o      out  1            write enable; constant 0
wbm_cyc_o     out  1            Wishbone cycle
wbm_stb_o     out  1            Wishbone strobe; always equal to wbm_cyc_o
wbm_dat_i     in   DWIDTH       Wishbone read data
wbm_ack_i     in   1            Wishbone acknowledge
wbm_err_i     in   1            Wishbone error
q_o           out  DWIDTH       FIFO head data
q_valid_o     out  1            FIFO non-empty
q_ready_i     in   1            consumer accepts the head word

Behaviour:
- Reset, asynchronous and active-low. All outputs are cleared and the state is:
  - busy_o, done_o, err_o, wbm_cyc_o, wbm_stb_o, q_valid_o = 0
  - wbm_adr_o = 0, q_o = 0
  - FIFO empty, remaining count = 0
  - Any transfer in progress is abandoned; no done_o pulse is generated.
- Registered state: adr (AWIDTH), rem (CWIDTH), FIFO level (0..2), state.
- State IDLE:
  - busy_o = 0.
  - start_i=1 with count_i≠0: capture base_adr_i and count_i, clear err_o, enter RUN, busy_o=1 from the next cycle.
  - start_i=1 with count_i=0: clear err_o, pulse done_o next cycle, stay IDLE.
- State RUN, strobe generation:
  - wbm_stb_o is registered.
  - It is asserted in the next cycle iff rem_next>0, no error this cycle, and level_next<2.
  - At most one cycle is outstanding; wbm_adr_o = adr whenever wbm_stb_o=1.
- State RUN, wbm_ack_i=1 while stb=1:
  - Push wbm_dat_i into the FIFO.
  - adr <= adr+1, wrapping modulo 2^AWIDTH.
  - rem <= rem-1.
  - If rem becomes 0: drop cyc/stb next cycle, pulse done_o, return to IDLE.
- Back-to-back reads: stb stays high across an ack when the FIFO still has room. The address changes in the cycle after the ack.
- State RUN, wbm_err_i=1 while stb=1:
  - Abort: drop cyc/stb next cycle, set err_o, clear rem, pulse done_o, go IDLE.
  - The errored word is not pushed.
  - err_i has priority over a simultaneous ack_i.
- ack_i and err_i are ignored while stb=0.
- start_i is ignored while busy.
- FIFO:
  - q_o is the head word; q_valid_o = (level>0).
  - Pop occurs on q_valid_o & q_ready_i.
  - Push and pop in the same cycle leaves the level unchanged, with the data ordered correctly.
  - A push at level 2 is impossible by construction of the strobe rule.
  - FIFO contents survive done_o and error; they drain normally, including after IDLE.
- The next start may be accepted the cycle after done_o even if the FIFO is non-empty. Stb then waits for level<2.
- The master does not stall on q_ready_i except through the FIFO level.
- Minimum per-word latency is 1 cycle after ack. With the CSM slave, a read completes in 2 cycles (stb cycle plus ack cycle).

Test Plan:
- Basic read: count=4, base=0x10, slave acks 1 cycle after stb, q_ready_i=1 → addresses 0x10..0x13 in order; q_o matches mem[0x10..0x13]; one done_o pulse; busy_o falls with done_o; err_o=0.
- Backpressure: count=5, q_ready_i=0 → stb drops after 2 acks (level=2). Then assert ready → remaining 3 words read; output order intact; no lost or duplicated word.
- Wrap: base=0xFE, count=4, AWIDTH=8 → addresses 0xFE, 0xFF, 0x00, 0x01.
- Error: count=6, err_i on the 3rd strobe → 2 words delivered, err_o=1, done_o pulse, cyc=0; the next start clears err_o.
- Edge starts:
  - count=0 → done_o pulse with no cyc.
  - start_i while busy → ignored; adr/rem unchanged.
  - ack and err asserted together → treated as error.
- Reset mid-transfer: deassert rst_nreset_i during the 2nd outstanding read → cyc/stb/q_valid_o/busy_o drop immediately (asynchronously); no done_o; a fresh start then works normally.

Source files
------------

// File: rtl/vga_wbm_rdr_if.sv
// Wishbone classic-cycle bus between the VGA block reader (master) and a
// slave port such as the CLUT shared-memory port.
//   wbm_adr_o  word address            wbm_dat_o  write data
//   wbm_sel_o  byte selects            wbm_we_o   write enable
//   wbm_cyc_o  bus cycle               wbm_stb_o  strobe
//   wbm_dat_i  read data               wbm_ack_i  acknowledge
//   wbm_err_i  error termination
// Signal names keep the master-side _o/_i suffixes of the original ports.
interface vga_wbm_rdr_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
);
    logic [AWIDTH-1:0]   wbm_adr_o;
    logic [DWIDTH-1:0]   wbm_dat_o;
    logic [DWIDTH/8-1:0] wbm_sel_o;
    logic                wbm_we_o;
    logic                wbm_cyc_o;
    logic                wbm_stb_o;
    logic [DWIDTH-1:0]   wbm_dat_i;
    logic                wbm_ack_i;
    logic                wbm_err_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/vga_wbm_rdr.sv
// Wishbone classic-cycle block reader. Reads count_i consecutive words from
// base_adr_i onward, one single read cycle per word, and queues the data in a
// 2-entry FIFO presented as a valid/ready stream.
//   wb_clk_i      clock (rising edge)
//   rst_nreset_i  asynchronous active-low reset
//   start_i       start request, sampled only when idle
//   base_adr_i    first word address, captured on start
//   count_i       word count, captured on start (0 = no transfer)
//   busy_o        transfer in progress
//   done_o        one-cycle pulse at transfer end (normal or error)
//   err_o         sticky error flag, cleared by the next accepted start
//   wbm           Wishbone master port
//   q_o/q_valid_o/q_ready_i  FIFO head stream
module vga_wbm_rdr #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int CWIDTH = 8
) (
    input  logic              wb_clk_i,
    input  logic              rst_nreset_i,
    input  logic              start_i,
    input  logic [AWIDTH-1:0] base_adr_i,
    input  logic [CWIDTH-1:0] count_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    vga_wbm_rdr_if.master     wbm,
    output logic [DWIDTH-1:0] q_o,
    output logic              q_valid_o,
    input  logic              q_ready_i
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state, state_nxt;
    logic [AWIDTH-1:0] adr;
    logic [CWIDTH-1:0] rem, rem_nxt;
    logic [1:0]        lvl, lvl_nxt;
    logic              stb, stb_nxt;
    logic              done_r, done_nxt;
    logic              err_r;
    logic [DWIDTH-1:0] fifo0, fifo1;

    logic start_ok, resp_ack, resp_err, last, push, pop;

    always_comb begin
        start_ok = (state == ST_IDLE) && start_i;
        // error wins over a simultaneous ack; both ignored without strobe
        resp_err = stb && wbm.wbm_err_i;
        resp_ack = stb && wbm.wbm_ack_i && !wbm.wbm_err_i;
        last     = resp_ack && (rem == CWIDTH'(1));
        push     = resp_ack;
        pop      = (lvl != 2'd0) && q_ready_i;
        lvl_nxt  = lvl + 2'(push) - 2'(pop);

        rem_nxt = rem;
        if (start_ok)      rem_nxt = count_i;
        else if (resp_err) rem_nxt = '0;
        else if (resp_ack) rem_nxt = rem - CWIDTH'(1);

        // rem is zero whenever idle, so this only fires for a live transfer;
        // holding off at level 2 guarantees a push never meets a full FIFO
        stb_nxt = (rem_nxt != '0) && !resp_err && (lvl_nxt != 2'd2);

        state_nxt = state;
        if (start_ok && (count_i != '0))     state_nxt = ST_RUN;
        else if (resp_err || last)           state_nxt = ST_IDLE;

        done_nxt = (start_ok && (count_i == '0)) || resp_err || last;
    end

    always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            state  <= ST_IDLE;
            adr    <= '0;
            rem    <= '0;
            lvl    <= 2'd0;
            stb    <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            fifo0  <= '0;
            fifo1  <= '0;
        end else begin
            state  <= state_nxt;
            rem    <= rem_nxt;
            lvl    <= lvl_nxt;
            stb    <= stb_nxt;
            done_r <= done_nxt;

            if (start_ok)      adr <= base_adr_i;
            else if (push)     adr <= adr + AWIDTH'(1);

            if (start_ok)      err_r <= 1'b0;
            else if (resp_err) err_r <= 1'b1;

            // fifo0 is always the head; fifo1 only holds data at level 2
            case ({push, pop})
                2'b10: begin
                    if (lvl == 2'd0) fifo0 <= wbm.wbm_dat_i;
                    else             fifo1 <= wbm.wbm_dat_i;
                end
                2'b01: fifo0 <= fifo1;
                2'b11: begin
                    if (lvl == 2'd1) begin
                        fifo0 <= wbm.wbm_dat_i;
                    end else begin
                        fifo0 <= fifo1;
                        fifo1 <= wbm.wbm_dat_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wbm.wbm_adr_o = adr;
    assign wbm.wbm_dat_o = '0;
    assign wbm.wbm_sel_o = '1;
    assign wbm.wbm_we_o  = 1'b0;
    assign wbm.wbm_cyc_o = stb;
    assign wbm.wbm_stb_o = stb;

    assign busy_o    = (state == ST_RUN);
    assign done_o    = done_r;
    assign err_o     = err_r;
    assign q_o       = fifo0;
    assign q_valid_o = (lvl != 2'd0);

endmodule

// File: tb/tb_vga_wbm_rdr.sv
module tb_vga_wbm_rdr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base = '0;
    logic [7:0]  cnt = '0;
    logic        busy, done, err;
    logic [31:0] q;
    logic        q_valid;
    logic        q_ready = 1'b0;

    vga_wbm_rdr_if #(.DWIDTH(32), .AWIDTH(8)) bus ();

    vga_wbm_rdr #(.DWIDTH(32), .AWIDTH(8), .CWIDTH(8)) dut (
        .wb_clk_i     (clk),
        .rst_nreset_i (rst_n),
        .start_i      (start),
        .base_adr_i   (base),
        .count_i      (cnt),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .wbm          (bus.master),
        .q_o          (q),
        .q_valid_o    (q_valid),
        .q_ready_i    (q_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(logic [7:0] a);
        return 32'hC0DE_0000 | {16'h0, ~a, a};
    endfunction

    // Slave: registered response one cycle after a fresh strobe
    int          resp_cnt = 0;
    int          err_at   = 0;
    bit          both_mode = 1'b0;
    logic [7:0]  adr_log[$];
    logic [31:0] q_log[$];
    int          done_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wbm_ack_i <= 1'b0;
            bus.wbm_err_i <= 1'b0;
            bus.wbm_dat_i <= '0;
        end else begin
            bus.wbm_ack_i <= 1'b0;
            bus.wbm_err_i <= 1'b0;
            if (bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i && !bus.wbm_err_i) begin
                resp_cnt <= resp_cnt + 1;
                adr_log.push_back(bus.wbm_adr_o);
                bus.wbm_dat_i <= mem_word(bus.wbm_adr_o);
                if (resp_cnt + 1 == err_at) begin
                    bus.wbm_err_i <= 1'b1;
                    bus.wbm_ack_i <= both_mode;
                end else begin
                    bus.wbm_ack_i <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (q_valid && q_ready) q_log.push_back(q);
        if (done) done_cnt++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic [7:0] b, input logic [7:0] c);
        @(negedge clk);
        start = 1'b1; base = b; cnt = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit ok;
        int a0, q0, d0;
        logic [7:0] wrap_adr [4];

        // ---- reset state
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cyc", bus.wbm_cyc_o, 0);
        chk("rst_stb", bus.wbm_stb_o, 0);
        chk("rst_qvalid", q_valid, 0);
        chk("rst_adr", bus.wbm_adr_o, 0);
        chk("rst_q", q, 0);
        chk("const_sel", bus.wbm_sel_o, 4'hF);
        chk("const_we", bus.wbm_we_o, 0);
        chk("const_dat", bus.wbm_dat_o, 0);
        rst_n = 1'b1;
        tick(2);

        // ---- basic read, 4 words from 0x10
        q_ready = 1'b1;
        a0 = adr_log.size(); q0 = q_log.size(); d0 = done_cnt;
        start_xfer(8'h10, 8'd4);
        chk("basic_busy", busy, 1);
        chk("basic_stb", bus.wbm_stb_o, 1);
        chk("basic_adr0", bus.wbm_adr_o, 8'h10);
        wait_done(ok);
        chk("basic_timeout", ok, 1);
        chk("basic_busy_fall", busy, 0);
        chk("basic_cyc_end", bus.wbm_cyc_o, 0);
        chk("basic_err", err, 0);
        tick(6);
        chk("basic_nadr", adr_log.size() - a0, 4);
        chk("basic_nq", q_log.size() - q0, 4);
        chk("basic_ndone", done_cnt - d0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("basic_adr", adr_log[a0+i], 8'h10 + 8'(i));
            chk("basic_q", q_log[q0+i], mem_word(8'h10 + 8'(i)));
        end

        // ---- backpressure, 5 words from 0x20
        q_ready = 1'b0;
        a0 = adr_log.size(); q0 = q_log.size(); d0 = done_cnt;
        start_xfer(8'h20, 8'd5);
        tick(20);
        chk("bp_stall_nadr", adr_log.size() - a0, 2);
        chk("bp_stall_cyc", bus.wbm_cyc_o, 0);
        chk("bp_stall_busy", busy, 1);
        chk("bp_stall_qvalid", q_valid, 1);
        chk("bp_stall_head", q, mem_word(8'h20));
        q_ready = 1'b1;
        wait_done(ok);
        chk("bp_timeout", ok, 1);
        tick(6);
        chk("bp_nadr", adr_log.size() - a0, 5);
        chk("bp_nq", q_log.size() - q0, 5);
        chk("bp_ndone", done_cnt - d0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_adr", adr_log[a0+i], 8'h20 + 8'(i));
            chk("bp_q", q_log[q0+i], mem_word(8'h20 + 8'(i)));
        end

        // ---- address wrap
        wrap_adr[0] = 8'hFE; wrap_adr[1] = 8'hFF; wrap_adr[2] = 8'h00; wrap_adr[3] = 8'h01;
        a0 = adr_log.size(); q0 = q_log.size();
        start_xfer(8'hFE, 8'd4);
        wait_done(ok);
        chk("wrap_timeout", ok, 1);
        tick(6);
        chk("wrap_nq", q_log.size() - q0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_adr", adr_log[a0+i], wrap_adr[i]);
            chk("wrap_q", q_log[q0+i], mem_word(wrap_adr[i]));
        end

        // ---- error on 3rd strobe of 6
        a0 = adr_log.size(); q0 = q_log.size(); d0 = done_cnt;
        err_at = resp_cnt + 3;
        start_xfer(8'h30, 8'd6);
        wait_done(ok);
        chk("err_timeout", ok, 1);
        chk("err_flag", err, 1);
        chk("err_cyc", bus.wbm_cyc_o, 0);
        chk("err_busy", busy, 0);
        tick(6);
        chk("err_sticky", err, 1);
        chk("err_nadr", adr_log.size() - a0, 3);
        chk("err_nq", q_log.size() - q0, 2);
        chk("err_ndone", done_cnt - d0, 1);
        chk("err_q0", q_log[q0], mem_word(8'h30));
        chk("err_q1", q_log[q0+1], mem_word(8'h31));
        err_at = 0;

        // ---- count 0: done pulse, no cycle, clears err
        a0 = adr_log.size();
        start_xfer(8'h44, 8'd0);
        chk("zero_done", done, 1);
        chk("zero_err_clr", err, 0);
        chk("zero_busy", busy, 0);
        chk("zero_cyc", bus.wbm_cyc_o, 0);
        tick(4);
        chk("zero_nadr", adr_log.size() - a0, 0);

        // ---- start while busy is ignored
        a0 = adr_log.size(); q0 = q_log.size(); d0 = done_cnt;
        start_xfer(8'h40, 8'd3);
        start = 1'b1; base = 8'h80; cnt = 8'd9;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_adr", bus.wbm_adr_o, 8'h40);
        wait_done(ok);
        chk("busy_start_timeout", ok, 1);
        tick(6);
        chk("busy_start_nadr", adr_log.size() - a0, 3);
        chk("busy_start_nq", q_log.size() - q0, 3);
        chk("busy_start_ndone", done_cnt - d0, 1);
        chk("busy_start_adr2", adr_log[a0+2], 8'h42);

        // ---- ack and err together count as error
        a0 = adr_log.size(); q0 = q_log.size();
        both_mode = 1'b1;
        err_at = resp_cnt + 2;
        start_xfer(8'h50, 8'd4);
        wait_done(ok);
        chk("both_timeout", ok, 1);
        chk("both_err", err, 1);
        tick(6);
        chk("both_nadr", adr_log.size() - a0, 2);
        chk("both_nq", q_log.size() - q0, 1);
        chk("both_q0", q_log[q0], mem_word(8'h50));
        err_at = 0;
        both_mode = 1'b0;

        // ---- reset during 2nd outstanding read
        q_ready = 1'b0;
        a0 = adr_log.size();
        start_xfer(8'h60, 8'd4);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (adr_log.size() - a0 == 1 && bus.wbm_stb_o && !bus.wbm_ack_i) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("rstmid_timeout", ok, 1);
        chk("rstmid_pre_qvalid", q_valid, 1);
        chk("rstmid_pre_adr", bus.wbm_adr_o, 8'h61);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_cyc", bus.wbm_cyc_o, 0);
        chk("rstmid_stb", bus.wbm_stb_o, 0);
        chk("rstmid_qvalid", q_valid, 0);
        chk("rstmid_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("rstmid_nodone", done_cnt - d0, 0);

        q_ready = 1'b1;
        a0 = adr_log.size(); q0 = q_log.size(); d0 = done_cnt;
        start_xfer(8'h70, 8'd2);
        wait_done(ok);
        chk("fresh_timeout", ok, 1);
        tick(6);
        chk("fresh_nq", q_log.size() - q0, 2);
        chk("fresh_ndone", done_cnt - d0, 1);
        chk("fresh_q0", q_log[q0], mem_word(8'h70));
        chk("fresh_q1", q_log[q0+1], mem_word(8'h71));
        chk("fresh_adr1", adr_log[a0+1], 8'h71);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
